uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Command-driven host controller sitting between the UART (rx/tx byte interfaces) and the CPU core with its instruction and data memories. It replaces the fixed load-all/run/dump-all sequence with a byte-command protocol: partial IMEM loads at any start address, CPU runs for a programmed number of cycles, and partial DMEM dumps. Every size is parametrised, and the block adds ACK/NAK responses and tx-error abort.

## Interface
Parameters:
- IMEM_BYTE_ADDR_WIDTH, 6, IMEM byte address width (1..8)
- DMEM_BYTE_ADDR_WIDTH, 6, DMEM byte address width (1..8)
- RUN_CYCLES_WIDTH, 16, run counter width (1..16)

Ports (single clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- rx_ready  in  1  UART byte-available level; a rising edge means one new byte
- rx_data  in  8  received byte, stable while rx_ready is high
- tx_empty  in  1  UART transmitter can accept a byte
- tx_error  in  1  UART transmit fault
- dmem_rd_data  in  8  DMEM byte at dmem_addr, combinational read
- cpu_rst  out  1  holds CPU in reset
- imem_ctrl  out  1  host owns IMEM ports (equals cpu_rst)
- dmem_ctrl  out  1  host owns DMEM ports (equals cpu_rst)
- imem_wr_en  out  1  write rx_data to imem_addr
- imem_addr  out  IMEM_BYTE_ADDR_WIDTH  IMEM byte address
- dmem_rd_en  out  1  DMEM byte consumed this cycle
- dmem_addr  out  DMEM_BYTE_ADDR_WIDTH  DMEM byte address
- tx_req  out  1  single-cycle send strobe
- tx_data  out  8  byte to send, valid when tx_req is high
- err_flag  out  1  sticky: last command was rejected or aborted

## Operation
- rx_strobe is the registered rising edge of rx_ready, one cycle wide. A byte is accepted only on rx_strobe.
- States: IDLE, ARG0, ARG1, LOAD, RUN, DUMP, RESP.
- IDLE + rx_strobe:
  - 0x4C 'L' → ARG0
  - 0x52 'R' → ARG0
  - 0x44 'D' → ARG0
  - any other byte → RESP with 0x15 (NAK), err_flag=1
  - A valid command byte clears err_flag.
- ARG0: the byte is latched as start address for L/D, or run-count high byte for R. Goes to ARG1.
- ARG1: the byte is latched as length-1 for L/D, or run-count low byte for R. Goes to LOAD, DUMP or RUN.
- Start addresses and the count are truncated to the parameter width (low bits kept).
- LOAD: each rx_strobe writes one byte (imem_wr_en=1, imem_addr=current), then the address increments modulo 2^IMEM_BYTE_ADDR_WIDTH. After L+1 bytes → RESP with 0x06 (ACK).
- RUN: cpu_rst=0 for exactly N cycles, N = {hi,lo} truncated. Then → RESP with 0x06. N=0 → RESP directly; cpu_rst never drops. rx_strobe is ignored in RUN.
- DUMP: sends L+1 bytes from start, address wrapping modulo 2^DMEM_BYTE_ADDR_WIDTH, tx_data=dmem_rd_data. After the last byte → IDLE (no ACK).
- tx_error seen in DUMP or RESP → abort to IDLE, err_flag=1.
- Transmit handshake:
  - tx_req fires only when tx_empty=1 and tx_busy=0.
  - tx_req sets tx_busy; tx_busy clears on the first cycle tx_empty=0.
  - dmem_rd_en = tx_req in DUMP.
- cpu_rst=1 in every state except RUN.

## Timing
- Reset (async, any state, mid-operation included):
  - state=IDLE, counters and addresses cleared.
  - cpu_rst=imem_ctrl=dmem_ctrl=1.
  - imem_wr_en=dmem_rd_en=tx_req=0, tx_data=0, err_flag=0.
  - Edge detector cleared, so an rx_ready already high at release is not a byte.
- rx_ready rise at cycle t → rx_strobe at t+1. In LOAD, imem_wr_en is asserted at t+1 with imem_addr valid that cycle.
- RUN entered at cycle t: cpu_rst low for cycles t..t+N-1, high again from t+N. RESP tx_req no earlier than t+N+1.
- Consecutive tx_req pulses are at least 2 cycles apart and each waits for a tx_empty low→high cycle.
- An rx_strobe on the same cycle as the last DUMP/RESP tx_req is dropped (not buffered).
- Length 0xFF with address width < 8 wraps the address repeatedly. The count is always L+1.

## Structure
- Package `uart_cmd_pkg` holds:
  - state enum `uart_cmd_state_e`
  - command constants CMD_LOAD=8'h4C, CMD_RUN=8'h52, CMD_DUMP=8'h44
  - response constants RSP_ACK=8'h06, RSP_NAK=8'h15
- Sub-module `pos_edge_detector_n`: rising-edge detector with async active-low reset, instantiated once for rx_ready.
- One state register, one 8-bit length/byte counter, one RUN_CYCLES_WIDTH down-counter, and two address counters.

## Test plan
- Load: 'L',0x3C,0x07, then 8 bytes (IMEM width 6) → writes at addresses 0x3C..0x3F then 0x00..0x03, then ACK 0x06; cpu_rst stays 1 throughout.
- Run: 'R',0x00,0x05 → cpu_rst low for exactly 5 cycles, then tx_data=0x06. 'R',0x00,0x00 → ACK, cpu_rst never drops.
- Dump: 'D',0x10,0x03 with DMEM[0x10..0x13]=A0..A3 → 4 tx_req pulses with tx_data A0,A1,A2,A3, each after a tx_empty low→high cycle; dmem_rd_en matches tx_req.
- Bad command 0x7A → NAK 0x15 and err_flag=1; a following 'D' clears err_flag.
- tx_error asserted after the 2nd byte of 'D',0x00,0x09 → no further tx_req, state IDLE, err_flag=1.
- rst_n pulled low mid-LOAD and mid-RUN → outputs take reset values that same cycle. rx_ready held high across release → no byte accepted.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and byte constants for the UART command controller.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG0,
    ST_ARG1,
    ST_LOAD,
    ST_RUN,
    ST_DUMP,
    ST_RESP
  } uart_cmd_state_e;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_DUMP = 8'h44;

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  // True for the three opcodes the controller understands.
  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_LOAD) || (b == CMD_RUN) || (b == CMD_DUMP);
  endfunction

endpackage

// File: rtl/pos_edge_detector_n.sv
// Registered rising-edge detector with asynchronous active-low reset.
// The first cycle after reset only primes the history register, so a level
// that is already high when reset is released never produces a pulse.
module pos_edge_detector_n (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic level_q;
  logic armed_q;

  // Track previous level and emit a one-cycle pulse on a low-to-high change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      armed_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      armed_q <= 1'b1;
      pulse   <= armed_q && level && !level_q;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Byte-command host controller between the UART and the CPU/IMEM/DMEM.
// Commands: 'L' addr len-1 <bytes>  load IMEM, ACK when done
//           'R' hi lo                release the CPU for {hi,lo} cycles, then ACK
//           'D' addr len-1           stream DMEM bytes out (no ACK)
// Anything else is answered with NAK and sets the sticky error flag.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int IMEM_BYTE_ADDR_WIDTH = 6,
  parameter int DMEM_BYTE_ADDR_WIDTH = 6,
  parameter int RUN_CYCLES_WIDTH     = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx_ready,
  input  logic [7:0]                      rx_data,
  input  logic                            tx_empty,
  input  logic                            tx_error,
  input  logic [7:0]                      dmem_rd_data,
  output logic                            cpu_rst,
  output logic                            imem_ctrl,
  output logic                            dmem_ctrl,
  output logic                            imem_wr_en,
  output logic [IMEM_BYTE_ADDR_WIDTH-1:0] imem_addr,
  output logic                            dmem_rd_en,
  output logic [DMEM_BYTE_ADDR_WIDTH-1:0] dmem_addr,
  output logic                            tx_req,
  output logic [7:0]                      tx_data,
  output logic                            err_flag
);

  uart_cmd_state_e               state_q;
  uart_cmd_state_e               state_d;
  logic                          rx_strobe;
  logic [7:0]                    cmd_q;
  logic [7:0]                    len_cnt_q;
  logic [RUN_CYCLES_WIDTH-1:0]   run_cnt_q;
  logic [15:0]                   run_word;
  logic [RUN_CYCLES_WIDTH-1:0]   run_load;
  logic                          tx_busy_q;
  logic                          launch;

  pos_edge_detector_n u_rx_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (rx_ready),
    .pulse (rx_strobe)
  );

  // During ARG1 of an 'R' command the high count byte is parked in len_cnt_q.
  assign run_word = {len_cnt_q, rx_data};
  assign run_load = run_word[RUN_CYCLES_WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode, transmit launch decision and combinational outputs.
  always_comb begin
    state_d    = state_q;
    launch     = 1'b0;
    imem_wr_en = 1'b0;
    cpu_rst    = (state_q != ST_RUN);
    imem_ctrl  = (state_q != ST_RUN);
    dmem_ctrl  = (state_q != ST_RUN);

    // tx_req is registered, so a byte chosen here goes out next cycle; the
    // busy flag (set with the launch) blocks a second launch until the UART
    // has shown tx_empty low.
    if ((state_q == ST_DUMP) || (state_q == ST_RESP))
      launch = tx_empty && !tx_busy_q && !tx_error;

    case (state_q)
      ST_IDLE: begin
        if (rx_strobe) state_d = is_cmd(rx_data) ? ST_ARG0 : ST_RESP;
      end
      ST_ARG0: begin
        if (rx_strobe) state_d = ST_ARG1;
      end
      ST_ARG1: begin
        if (rx_strobe) begin
          if (cmd_q == CMD_LOAD)      state_d = ST_LOAD;
          else if (cmd_q == CMD_DUMP) state_d = ST_DUMP;
          else if (run_load == '0)    state_d = ST_RESP;
          else                        state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (rx_strobe) begin
          imem_wr_en = 1'b1;
          if (len_cnt_q == 8'd0) state_d = ST_RESP;
        end
      end
      ST_RUN: begin
        if (run_cnt_q == RUN_CYCLES_WIDTH'(1)) state_d = ST_RESP;
      end
      // Leave only once the last strobe is actually on the wire, so an rx
      // byte arriving in that same cycle is still ignored.
      ST_DUMP: begin
        if (tx_error || (tx_req && (len_cnt_q == 8'd0))) state_d = ST_IDLE;
      end
      ST_RESP: begin
        if (tx_error || tx_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Argument latches, counters, address pointers, transmit path and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= '0;
      len_cnt_q  <= '0;
      run_cnt_q  <= '0;
      imem_addr  <= '0;
      dmem_addr  <= '0;
      tx_busy_q  <= 1'b0;
      tx_req     <= 1'b0;
      tx_data    <= '0;
      dmem_rd_en <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      tx_req     <= launch;
      dmem_rd_en <= launch && (state_q == ST_DUMP);
      // In RESP the error flag tells NAK from ACK: a valid opcode cleared it.
      if (launch)
        tx_data <= (state_q == ST_DUMP) ? dmem_rd_data : (err_flag ? RSP_NAK : RSP_ACK);
      if (launch)         tx_busy_q <= 1'b1;
      else if (!tx_empty) tx_busy_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (rx_strobe) begin
            cmd_q    <= rx_data;
            err_flag <= !is_cmd(rx_data);
          end
        end
        ST_ARG0: begin
          if (rx_strobe) begin
            if (cmd_q == CMD_LOAD)      imem_addr <= rx_data[IMEM_BYTE_ADDR_WIDTH-1:0];
            else if (cmd_q == CMD_DUMP) dmem_addr <= rx_data[DMEM_BYTE_ADDR_WIDTH-1:0];
            else                        len_cnt_q <= rx_data;
          end
        end
        ST_ARG1: begin
          if (rx_strobe) begin
            if (cmd_q == CMD_RUN) run_cnt_q <= run_load;
            else                  len_cnt_q <= rx_data;
          end
        end
        ST_LOAD: begin
          if (rx_strobe) begin
            imem_addr <= imem_addr + 1'b1;
            len_cnt_q <= len_cnt_q - 8'd1;
          end
        end
        ST_RUN: begin
          run_cnt_q <= run_cnt_q - 1'b1;
        end
        ST_DUMP: begin
          if (tx_error) begin
            err_flag <= 1'b1;
          end else if (tx_req) begin
            dmem_addr <= dmem_addr + 1'b1;
            len_cnt_q <= len_cnt_q - 8'd1;
          end
        end
        ST_RESP: begin
          if (tx_error) err_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: randomized command traffic against
// an address/queue model of the command protocol, plus a simple UART model.
module tb_uart_cmd_ctrl;

  localparam int IW = 6;
  localparam int DW = 6;
  localparam int RW = 16;
  localparam int IDEPTH = 1 << IW;
  localparam int DDEPTH = 1 << DW;

  localparam logic [7:0] C_L   = 8'h4C;
  localparam logic [7:0] C_R   = 8'h52;
  localparam logic [7:0] C_D   = 8'h44;
  localparam logic [7:0] R_ACK = 8'h06;
  localparam logic [7:0] R_NAK = 8'h15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          tx_empty;
  logic          tx_error;
  logic [7:0]    dmem_rd_data;
  logic          cpu_rst, imem_ctrl, dmem_ctrl, imem_wr_en, dmem_rd_en, tx_req, err_flag;
  logic [IW-1:0] imem_addr;
  logic [DW-1:0] dmem_addr;
  logic [7:0]    tx_data;

  logic [7:0]    dmem_mem [0:DDEPTH-1];

  int n_tests = 0;
  int n_fail  = 0;

  // Observation state filled by the monitor.
  int       cyc = 0;
  logic [7:0] tx_q[$];
  logic     txrd_q[$];
  int       txcyc_q[$];
  int       wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int       cpu_low_cnt = 0;
  int       low_runs = 0;
  int       rise_cyc = 0;
  int       gap_bad = 0;
  int       rd_orphan = 0;
  int       ctrl_bad = 0;
  logic     saw_low = 1'b1;
  logic     prev_cpu = 1'b1;

  uart_cmd_ctrl #(
    .IMEM_BYTE_ADDR_WIDTH (IW),
    .DMEM_BYTE_ADDR_WIDTH (DW),
    .RUN_CYCLES_WIDTH     (RW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .tx_empty     (tx_empty),
    .tx_error     (tx_error),
    .dmem_rd_data (dmem_rd_data),
    .cpu_rst      (cpu_rst),
    .imem_ctrl    (imem_ctrl),
    .dmem_ctrl    (dmem_ctrl),
    .imem_wr_en   (imem_wr_en),
    .imem_addr    (imem_addr),
    .dmem_rd_en   (dmem_rd_en),
    .dmem_addr    (dmem_addr),
    .tx_req       (tx_req),
    .tx_data      (tx_data),
    .err_flag     (err_flag)
  );

  always #5 clk = ~clk;

  assign dmem_rd_data = dmem_mem[dmem_addr];

  // Monitor on the inactive edge: record writes, sent bytes and cpu_rst behaviour.
  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_cpu <= cpu_rst;
    if (cpu_rst && !prev_cpu) rise_cyc <= cyc;
    if (!rst_n) begin
      saw_low <= 1'b1;
    end else begin
      if (imem_wr_en) begin
        wr_addr_q.push_back(int'(imem_addr));
        wr_data_q.push_back(rx_data);
      end
      if (tx_req) begin
        tx_q.push_back(tx_data);
        txrd_q.push_back(dmem_rd_en);
        txcyc_q.push_back(cyc);
        if (!saw_low) gap_bad <= gap_bad + 1;
        saw_low <= 1'b0;
      end else if (!tx_empty) begin
        saw_low <= 1'b1;
      end
      if (dmem_rd_en && !tx_req) rd_orphan <= rd_orphan + 1;
      if (!cpu_rst) cpu_low_cnt <= cpu_low_cnt + 1;
      if (!cpu_rst && prev_cpu) low_runs <= low_runs + 1;
      if ((imem_ctrl !== cpu_rst) || (dmem_ctrl !== cpu_rst)) ctrl_bad <= ctrl_bad + 1;
    end
  end

  // UART transmitter model: after each request, optionally stay "empty" a
  // little, then go busy for a few cycles before becoming empty again.
  initial begin
    tx_empty = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (tx_req) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        tx_empty = 1'b0;
        repeat ($urandom_range(2, 4)) begin @(posedge clk); #2; end
        tx_empty = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick(2);
    rx_ready = 1'b0;
    tick(2);
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b);
    send_byte(c);
    send_byte(a);
    send_byte(b);
  endtask

  task automatic clear_q();
    tx_q.delete();
    txrd_q.delete();
    txcyc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while ((tx_q.size() < n) && (k < 3000)) begin
      tick(1);
      k++;
    end
  endtask

  task automatic fill_dmem();
    for (int i = 0; i < DDEPTH; i++) dmem_mem[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    rx_ready = 1'b1;
    rx_data  = 8'h7A;
    tx_error = 1'b0;
    fill_dmem();
    tick(3);
    n_tests++;
    if ({cpu_rst, imem_ctrl, dmem_ctrl, imem_wr_en, dmem_rd_en, tx_req, err_flag} !== 7'b1110000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, want 1110000", {cpu_rst, imem_ctrl, dmem_ctrl, imem_wr_en, dmem_rd_en, tx_req, err_flag});
    end
    n_tests++;
    if ({tx_data, imem_addr, dmem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: tx_data %h imem_addr %h dmem_addr %h, want 0", tx_data, imem_addr, dmem_addr);
    end
    clear_q();
    rst_n = 1'b1;
    tick(12);
    n_tests++;
    if ((tx_q.size() != 0) || (err_flag !== 1'b0)) begin
      n_fail++;
      $display("FAIL reset_rx_high: tx bytes %0d err %b, want 0 and 0", tx_q.size(), err_flag);
    end
    rx_ready = 1'b0;
    tick(2);
  endtask

  task automatic check_load(input logic [7:0] start, input logic [7:0] len, input string nm);
    logic [7:0] data [$];
    int runs0;
    runs0 = low_runs;
    clear_q();
    send_cmd(C_L, start, len);
    for (int i = 0; i <= int'(len); i++) begin
      data.push_back(8'($urandom));
      send_byte(data[i]);
    end
    wait_tx(1);
    tick(10);
    n_tests++;
    if (wr_addr_q.size() != int'(len) + 1) begin
      n_fail++;
      $display("FAIL %s count: got %0d writes, want %0d", nm, wr_addr_q.size(), int'(len) + 1);
    end
    for (int i = 0; i < wr_addr_q.size() && i <= int'(len); i++) begin
      n_tests++;
      if ((wr_addr_q[i] != (int'(start) + i) % IDEPTH) || (wr_data_q[i] !== data[i])) begin
        n_fail++;
        $display("FAIL %s write%0d: got @%h=%h, want @%h=%h", nm, i, wr_addr_q[i], wr_data_q[i],
                 (int'(start) + i) % IDEPTH, data[i]);
      end
    end
    n_tests++;
    if ((tx_q.size() != 1) || (tx_q[0] !== R_ACK) || (txrd_q[0] !== 1'b0)) begin
      n_fail++;
      $display("FAIL %s ack: %0d bytes, first %h, want one 06", nm, tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00);
    end
    n_tests++;
    if (low_runs != runs0) begin
      n_fail++;
      $display("FAIL %s cpu_rst: dropped %0d times, want 0", nm, low_runs - runs0);
    end
  endtask

  task automatic test_load();
    check_load(8'h3C, 8'h07, "load_spec");
    check_load(8'($urandom), 8'h00, "load_len0");
    check_load(8'($urandom), 8'($urandom_range(1, 15)), "load_rand");
    check_load(8'($urandom), 8'd70, "load_wrap");
  endtask

  task automatic test_run();
    int ns [4];
    int n, low0, runs0;
    ns[0] = 5;
    ns[1] = 0;
    ns[2] = 259;
    ns[3] = $urandom_range(1, 40);
    for (int k = 0; k < 4; k++) begin
      n     = ns[k];
      low0  = cpu_low_cnt;
      runs0 = low_runs;
      clear_q();
      send_cmd(C_R, 8'(n >> 8), 8'(n & 255));
      wait_tx(1);
      tick(2);
      n_tests++;
      if ((cpu_low_cnt - low0 != n) || (low_runs - runs0 != ((n != 0) ? 1 : 0))) begin
        n_fail++;
        $display("FAIL run%0d cycles: low %0d cycles in %0d spans, want %0d", n, cpu_low_cnt - low0, low_runs - runs0, n);
      end
      n_tests++;
      if ((tx_q.size() != 1) || (tx_q[0] !== R_ACK)) begin
        n_fail++;
        $display("FAIL run%0d ack: %0d bytes, first %h, want one 06", n, tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00);
      end
      if (n != 0 && tx_q.size() > 0) begin
        n_tests++;
        if (txcyc_q[0] <= rise_cyc) begin
          n_fail++;
          $display("FAIL run%0d ack_timing: tx_req cycle %0d, cpu_rst high at %0d, want later", n, txcyc_q[0], rise_cyc);
        end
      end
    end
  endtask

  task automatic check_dump(input logic [7:0] start, input logic [7:0] len, input string nm);
    logic [7:0] exp;
    clear_q();
    send_cmd(C_D, start, len);
    wait_tx(int'(len) + 1);
    tick(30);
    n_tests++;
    if (tx_q.size() != int'(len) + 1) begin
      n_fail++;
      $display("FAIL %s count: got %0d bytes, want %0d", nm, tx_q.size(), int'(len) + 1);
    end
    for (int i = 0; i < tx_q.size() && i <= int'(len); i++) begin
      exp = dmem_mem[(int'(start) + i) % DDEPTH];
      n_tests++;
      if ((tx_q[i] !== exp) || (txrd_q[i] !== 1'b1)) begin
        n_fail++;
        $display("FAIL %s byte%0d: got %h rd_en %b, want %h rd_en 1", nm, i, tx_q[i], txrd_q[i], exp);
      end
    end
  endtask

  task automatic test_dump();
    fill_dmem();
    dmem_mem[16] = 8'hA0;
    dmem_mem[17] = 8'hA1;
    dmem_mem[18] = 8'hA2;
    dmem_mem[19] = 8'hA3;
    check_dump(8'h10, 8'h03, "dump_spec");
    check_dump(8'($urandom), 8'($urandom_range(0, 20)), "dump_rand");
    check_dump(8'($urandom), 8'd80, "dump_wrap");
  endtask

  task automatic test_bad_cmd();
    clear_q();
    send_byte(8'h7A);
    wait_tx(1);
    tick(2);
    n_tests++;
    if ((tx_q.size() != 1) || (tx_q[0] !== R_NAK) || (err_flag !== 1'b1)) begin
      n_fail++;
      $display("FAIL bad_cmd: %0d bytes first %h err %b, want one 15 err 1", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00, err_flag);
    end
    send_byte(C_D);
    n_tests++;
    if (err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_cmd_clear: err %b, want 0", err_flag);
    end
    clear_q();
    send_byte(8'h20);
    send_byte(8'h00);
    wait_tx(1);
    tick(20);
    n_tests++;
    if ((tx_q.size() != 1) || (tx_q[0] !== dmem_mem[32])) begin
      n_fail++;
      $display("FAIL bad_cmd_dump: %0d bytes first %h, want one %h", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00, dmem_mem[32]);
    end
  endtask

  task automatic test_tx_error();
    clear_q();
    send_cmd(C_D, 8'h00, 8'h09);
    wait_tx(2);
    tx_error = 1'b1;
    tick(3);
    tx_error = 1'b0;
    tick(40);
    n_tests++;
    if ((tx_q.size() != 2) || (err_flag !== 1'b1)) begin
      n_fail++;
      $display("FAIL tx_error_abort: %0d bytes err %b, want 2 bytes err 1", tx_q.size(), err_flag);
    end
    clear_q();
    send_cmd(C_R, 8'h00, 8'h00);
    wait_tx(1);
    tick(2);
    n_tests++;
    if ((tx_q.size() != 1) || (tx_q[0] !== R_ACK) || (err_flag !== 1'b0)) begin
      n_fail++;
      $display("FAIL tx_error_idle: %0d bytes first %h err %b, want one 06 err 0", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00, err_flag);
    end
  endtask

  task automatic test_reset_mid();
    int k, low0;
    clear_q();
    send_cmd(C_L, 8'h00, 8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_data  = 8'h33;
    rx_ready = 1'b1;
    tick(1);
    n_tests++;
    if (imem_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_load_wr: imem_wr_en %b, want 1", imem_wr_en);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({imem_wr_en, cpu_rst, tx_req, err_flag, imem_addr} !== {4'b0100, {IW{1'b0}}}) begin
      n_fail++;
      $display("FAIL mid_load_reset: wr %b cpu_rst %b tx_req %b err %b addr %h, want 0 1 0 0 0",
               imem_wr_en, cpu_rst, tx_req, err_flag, imem_addr);
    end
    rx_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(30);
    n_tests++;
    if ((tx_q.size() != 0) || (wr_addr_q.size() != 2)) begin
      n_fail++;
      $display("FAIL mid_load_after: %0d bytes %0d writes, want 0 and 2", tx_q.size(), wr_addr_q.size());
    end
    clear_q();
    low0 = cpu_low_cnt;
    send_cmd(C_R, 8'h00, 8'h40);
    k = 0;
    while ((cpu_rst !== 1'b0) && (k < 50)) begin tick(1); k++; end
    tick(3);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({cpu_rst, imem_ctrl, dmem_ctrl} !== 3'b111) begin
      n_fail++;
      $display("FAIL mid_run_reset: cpu_rst %b imem_ctrl %b dmem_ctrl %b, want 111", cpu_rst, imem_ctrl, dmem_ctrl);
    end
    tick(2);
    rst_n = 1'b1;
    tick(100);
    n_tests++;
    if ((tx_q.size() != 0) || (cpu_low_cnt - low0 < 1) || (cpu_low_cnt - low0 > 10)) begin
      n_fail++;
      $display("FAIL mid_run_after: %0d bytes, low %0d cycles, want 0 bytes and 1..10 cycles", tx_q.size(), cpu_low_cnt - low0);
    end
  endtask

  task automatic test_invariants();
    n_tests++;
    if ((gap_bad != 0) || (rd_orphan != 0) || (ctrl_bad != 0)) begin
      n_fail++;
      $display("FAIL invariants: gap %0d rd_orphan %0d ctrl %0d, want all 0", gap_bad, rd_orphan, ctrl_bad);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    tx_error = 1'b0;
    test_reset();
    test_load();
    test_run();
    test_dump();
    test_bad_cmd();
    test_tx_error();
    test_reset_mid();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
